// File: rtl/pc_return_stack.sv
// pc_return_stack: PC sequencing control (load/increment/hold) with a circular return-address stack.
module pc_return_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] target,
  input  logic              flag_clr,
  output logic              pc_load,
  output logic              pc_inc,
  output logic [ADDR_W-1:0] pc_d,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     ptr_q, ptr_d, ptr_inc, ptr_dec, wr_idx;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] pc_d_q, pc_d_d, ret_addr;
  logic              pc_load_q, pc_load_d, pc_inc_q, pc_inc_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              do_push, do_tail, do_pop, do_unf;
  assign empty     = count_q == '0;
  assign full      = count_q == CNT_W'(DEPTH);
  assign count     = count_q;
  assign pc_load   = pc_load_q;
  assign pc_inc    = pc_inc_q;
  assign pc_d      = pc_d_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign ret_addr  = pc_in + 1'b1;
  // ptr_q points at the next free slot; the top entry lives at ptr_q-1.
  assign ptr_inc = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;
  // A tail call on an empty stack degrades to a plain push.
  assign do_push = call & (~ret | empty);
  assign do_tail = call & ret & ~empty;
  assign do_pop  = ret & ~call & ~empty;
  assign do_unf  = ret & ~call & empty;
  assign wr_idx  = do_tail ? ptr_dec : ptr_q;
  always_comb begin
    count_d   = (do_push & ~full) ? count_q + 1'b1 : do_pop ? count_q - 1'b1 : count_q;
    ptr_d     = do_push ? ptr_inc : do_pop ? ptr_dec : ptr_q;
    pc_load_d = call | do_pop;
    pc_inc_d  = run & ~pc_load_d;
    pc_d_d    = call ? target : do_pop ? mem_q[ptr_dec] : pc_d_q;
    ovf_d     = (do_push & full) | (ovf_q & ~flag_clr);
    unf_d     = do_unf | (unf_q & ~flag_clr);
  end
  always_ff @(posedge clk) begin
    if (call) mem_q[wr_idx] <= ret_addr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      count_q   <= '0;
      pc_d_q    <= '0;
      pc_load_q <= 1'b0;
      pc_inc_q  <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      pc_d_q    <= pc_d_d;
      pc_load_q <= pc_load_d;
      pc_inc_q  <= pc_inc_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end
endmodule

// File: tb/tb_pc_return_stack.sv
// tb_pc_return_stack: directed self-checking bench for pc_return_stack.
module tb_pc_return_stack;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0, call = 1'b0, ret = 1'b0, flag_clr = 1'b0;
  logic [11:0] pc_in = '0, target = '0;
  logic        pc_load, pc_inc, empty, full, overflow, underflow;
  logic [11:0] pc_d;
  logic [3:0]  count;
  int          vectors = 0;
  int          miscompares = 0;

  pc_return_stack dut (
    .clk(clk), .rst_n(rst_n), .run(run), .call(call), .ret(ret),
    .pc_in(pc_in), .target(target), .flag_clr(flag_clr),
    .pc_load(pc_load), .pc_inc(pc_inc), .pc_d(pc_d), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic r, input logic [11:0] pc, input logic [11:0] tg);
    call = c; ret = r; pc_in = pc; target = tg;
    step();
  endtask

  initial begin
    step(); step();
    chk("rst_load", pc_load, 0); chk("rst_inc", pc_inc, 0); chk("rst_pcd", pc_d, 0);
    chk("rst_count", count, 0); chk("rst_empty", empty, 1);
    chk("rst_ovf", overflow, 0); chk("rst_unf", underflow, 0);
    rst_n = 1'b1; run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("run_inc", pc_inc, 1); chk("run_load", pc_load, 0);
      chk("run_count", count, 0); chk("run_empty", empty, 1);
    end
    drive(1, 0, 12'h100, 12'h200);
    chk("call_load", pc_load, 1); chk("call_inc", pc_inc, 0);
    chk("call_pcd", pc_d, 12'h200); chk("call_count", count, 1); chk("call_empty", empty, 0);
    drive(0, 1, 12'h200, 12'h000);
    chk("ret_load", pc_load, 1); chk("ret_pcd", pc_d, 12'h101);
    chk("ret_count", count, 0); chk("ret_empty", empty, 1);
    drive(0, 0, 12'h101, 12'h000);
    chk("idle_load", pc_load, 0); chk("idle_inc", pc_inc, 1); chk("idle_pcd", pc_d, 12'h101);
    drive(1, 0, 12'h010, 12'h400); chk("nest_c1", count, 1);
    drive(1, 0, 12'h020, 12'h500); chk("nest_c2", count, 2);
    drive(1, 0, 12'h030, 12'h600); chk("nest_c3", count, 3); chk("nest_tgt", pc_d, 12'h600);
    drive(0, 1, 12'h600, 12'h000); chk("nest_r1", pc_d, 12'h031); chk("nest_r1c", count, 2);
    drive(0, 1, 12'h031, 12'h000); chk("nest_r2", pc_d, 12'h021); chk("nest_r2c", count, 1);
    drive(0, 1, 12'h021, 12'h000); chk("nest_r3", pc_d, 12'h011); chk("nest_r3c", count, 0);
    for (int i = 0; i < 9; i++) drive(1, 0, 12'(i), 12'h700);
    chk("ovf_full", full, 1); chk("ovf_count", count, 8); chk("ovf_flag", overflow, 1);
    chk("ovf_unf", underflow, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 12'h700, 12'h000);
      chk("deep_ret", pc_d, 12'(9 - i)); chk("deep_load", pc_load, 1);
    end
    chk("deep_empty", empty, 1);
    drive(0, 1, 12'h002, 12'h000);
    chk("unf_load", pc_load, 0); chk("unf_inc", pc_inc, 1); chk("unf_pcd", pc_d, 12'h002);
    chk("unf_flag", underflow, 1); chk("unf_ovf", overflow, 1); chk("unf_count", count, 0);
    flag_clr = 1'b1;
    drive(0, 1, 12'h002, 12'h000);
    chk("setwins_unf", underflow, 1); chk("setwins_ovf", overflow, 0);
    drive(0, 0, 12'h002, 12'h000);
    chk("clr_unf", underflow, 0); chk("clr_ovf", overflow, 0);
    flag_clr = 1'b0;
    drive(1, 0, 12'hFFF, 12'h010); chk("wrap_count", count, 1);
    drive(0, 1, 12'h010, 12'h000); chk("wrap_pcd", pc_d, 12'h000);
    run = 1'b0;
    drive(1, 0, 12'h040, 12'h100); chk("norun_load", pc_load, 1); chk("norun_inc", pc_inc, 0);
    drive(1, 0, 12'h045, 12'h120); chk("tail_pre", count, 2);
    drive(1, 1, 12'h050, 12'h300);
    chk("tail_pcd", pc_d, 12'h300); chk("tail_count", count, 2); chk("tail_load", pc_load, 1);
    chk("tail_unf", underflow, 0);
    drive(0, 1, 12'h300, 12'h000); chk("tail_r1", pc_d, 12'h051); chk("tail_r1c", count, 1);
    drive(0, 1, 12'h051, 12'h000); chk("tail_r2", pc_d, 12'h041); chk("tail_r2c", count, 0);
    drive(0, 0, 12'h041, 12'h000); chk("hold_inc", pc_inc, 0); chk("hold_load", pc_load, 0);
    drive(1, 1, 12'h060, 12'h080);
    chk("tail0_count", count, 1); chk("tail0_unf", underflow, 0); chk("tail0_pcd", pc_d, 12'h080);
    drive(0, 1, 12'h080, 12'h000); chk("tail0_ret", pc_d, 12'h061);
    run = 1'b1;
    for (int i = 0; i < 5; i++) drive(1, 0, 12'(12'h0A0 + i), 12'h0B0);
    chk("ar_pre_count", count, 5); chk("ar_pre_load", pc_load, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_load", pc_load, 0); chk("ar_count", count, 0); chk("ar_pcd", pc_d, 0);
    chk("ar_empty", empty, 1);
    step();
    chk("ar_edge_load", pc_load, 0); chk("ar_edge_count", count, 0);
    #2 rst_n = 1'b1;
    drive(0, 1, 12'h0B0, 12'h000);
    chk("ar_ret_load", pc_load, 0); chk("ar_ret_unf", underflow, 1); chk("ar_ret_inc", pc_inc, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pc_return_stack.md
Name: pc_return_stack

Overview:
- Control-side companion of the 12-bit program counter: decides each cycle whether the PC loads, increments or holds, and supplies the load value.
- Holds a hardware return-address stack. A call pushes the return address (pc_in+1) and redirects the PC to the call target; a return pops the stack and redirects the PC to the popped address.
- Outputs pc_load, pc_inc and pc_d connect directly to the PC register's load, increment and D inputs.

Parameters:
- ADDR_W, 12, PC/address width in bits.
- DEPTH, 8, number of stack entries; must be ≥2.
- CNT_W, 4, width of the occupancy count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  1 = advance the PC sequentially when no call or return is pending; 0 = hold.
- call  input  1  pulse: push pc_in+1 and load target.
- ret  input  1  pulse: pop and load the popped address.
- pc_in  input  ADDR_W  current PC value (the PC register's Q).
- target  input  ADDR_W  call destination address.
- flag_clr  input  1  clears the sticky overflow and underflow flags.
- pc_load  output  1  registered; drives the PC's load input.
- pc_inc  output  1  registered; drives the PC's increment input.
- pc_d  output  ADDR_W  registered; drives the PC's D input.
- count  output  CNT_W  current stack occupancy, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky: a call occurred while the stack was full.
- underflow  output  1  sticky: a return occurred while the stack was empty.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc_load=0, pc_inc=0, pc_d=0, count=0, overflow=0, underflow=0.
  - Stack contents are don't-care; the read/write pointer is 0.
  - Reset asserted mid-operation aborts any pending action; the stack is empty afterwards.
- Timing:
  - All outputs are registered. An action sampled at edge N appears on pc_load/pc_inc/pc_d after edge N.
  - The PC consumes the outputs at edge N+1, giving one-cycle redirect latency.
  - pc_load and pc_inc are never both 1.
- Priority per cycle, evaluated on sampled inputs:
  - call=1, ret=0:
    - Push (pc_in+1) mod 2^ADDR_W, so 0xFFF wraps to 0x000.
    - pc_load=1, pc_d=target.
    - count increments, unless the stack was full: then the oldest entry is overwritten (circular), count stays DEPTH and overflow is set.
  - ret=1, call=0, count>0:
    - Pop the top entry; pc_load=1, pc_d=popped value; count decrements.
  - ret=1, call=0, count==0:
    - No load; underflow is set.
    - pc_inc=run and pc_d holds its previous value.
  - call=1 and ret=1 (tail call):
    - Top entry replaced with pc_in+1; pc_load=1, pc_d=target; count unchanged.
    - If count==0, behaves as a plain call and does not set underflow.
  - Neither call nor ret: pc_load=0, pc_inc=run, pc_d holds its previous value.
- Stack storage:
  - Circular buffer with a top pointer; the pointer wraps modulo DEPTH.
  - empty and full are combinational from count.
- Sticky flags:
  - flag_clr clears overflow and underflow on the next edge.
  - If flag_clr and a set condition occur in the same cycle, the set wins.
- run has no effect on call or ret; a call or return while run=0 still loads.

Test Plan:
- Reset then run=1 for 3 cycles → pc_inc=1 on each cycle after edge 1; pc_load=0; count=0; empty=1.
- Call from pc_in=0x100 with target=0x200 → next cycle pc_load=1, pc_d=0x200, count=1. Then ret → pc_load=1, pc_d=0x101, count=0, empty=1.
- Nested calls from pc_in=0x010, 0x020, 0x030, then 3 rets → pc_d sequence 0x031, 0x021, 0x011; count steps 3→0.
- DEPTH=8: 9 calls from pc_in=0x000..0x008, then 9 rets:
  - After the calls: full=1, overflow=1.
  - The first 8 rets return 0x009..0x002.
  - The 9th ret: no load, underflow=1.
  - Then flag_clr=1 clears both flags.
- Call from pc_in=0xFFF → pushed address 0x000. Simultaneous call+ret with count=2, pc_in=0x050, target=0x300 → pc_d=0x300, count stays 2; the next ret returns 0x051.
- Assert rst_n=0 asynchronously between edges with count=5 and pc_load=1 → outputs clear immediately, count=0; no load occurs on the following edge.
